ram_stream_reader: RTL and testbench

RAM_STREAM_READER -- requirements
Module: ram_stream_reader

---
 rtl/ram_stream_reader.sv | 179 +++++++++++++++++
 tb/tb_ram_stream_reader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_stream_reader.sv
// Streams cmd_len+1 consecutive RAM words out of a single read port into a valid/ready stream.
// Optional stall statistics are enabled by defining RAM_STREAM_READER_STATS_EN.
//
// state | meaning
// IDLE  | waiting for a command, cmd_ready high (once out of reset)
// RUN   | issuing reads, one per cycle while credit allows
// DRAIN | all reads issued, emptying pipeline and FIFO until the last beat
module ram_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [ADDR_WIDTH-1:0] cmd_len,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_rd_en,
    input  logic [DATA_WIDTH-1:0] ram_rdata,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           stall_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic                    armed;
    logic [ADDR_WIDTH-1:0]   issue_rem;
    logic [ADDR_WIDTH-1:0]   beat_rem;
    logic [RD_LATENCY-1:0]   vld_sr;
    logic [DATA_WIDTH-1:0]   fifo_mem [4];
    logic [1:0]              wr_ptr;
    logic [1:0]              rd_ptr;
    logic [2:0]              fifo_count;
    logic [2:0]              in_flight;
    logic                    credit;
    logic                    issue;
    logic                    accept;
    logic                    capture;
    logic                    pop;
    logic                    last_pop;

    always_comb begin
        in_flight = 3'd0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            in_flight = in_flight + 3'(vld_sr[i]);
        end
    end

    // Credit covers both buffered and in-flight words so the 4-entry FIFO can never overflow.
    assign credit   = ({1'b0, fifo_count} + {1'b0, in_flight}) < 4'd4;
    assign accept   = cmd_valid && cmd_ready;
    assign capture  = vld_sr[RD_LATENCY-1];
    assign pop      = m_valid && m_ready;
    assign last_pop = pop && m_last;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (issue && issue_rem == '0) state_nxt = DRAIN;
            DRAIN:   if (last_pop) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = armed && (state == IDLE);
        busy      = (state != IDLE);
        issue     = (state == RUN) && credit;
        ram_rd_en = issue;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            armed     <= 1'b0;
            ram_addr  <= '0;
            issue_rem <= '0;
            beat_rem  <= '0;
            done      <= 1'b0;
        end else begin
            armed <= 1'b1;
            done  <= (state == DRAIN) && last_pop;
            if (accept) begin
                ram_addr  <= cmd_addr;
                issue_rem <= cmd_len;
                beat_rem  <= cmd_len;
            end else begin
                if (issue) begin
                    ram_addr  <= ram_addr + 1'b1;
                    issue_rem <= issue_rem - 1'b1;
                end
                if (pop) begin
                    beat_rem <= beat_rem - 1'b1;
                end
            end
        end
    end

    if (RD_LATENCY == 1) begin : g_sr1
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                vld_sr <= '0;
            end else begin
                vld_sr <= issue;
            end
        end
    end else begin : g_srn
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                vld_sr <= '0;
            end else begin
                vld_sr <= {vld_sr[RD_LATENCY-2:0], issue};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            fifo_mem[wr_ptr] <= ram_rdata;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr     <= 2'd0;
            rd_ptr     <= 2'd0;
            fifo_count <= 3'd0;
        end else begin
            if (capture) wr_ptr <= wr_ptr + 2'd1;
            if (pop)     rd_ptr <= rd_ptr + 2'd1;
            case ({capture, pop})
                2'b10:   fifo_count <= fifo_count + 3'd1;
                2'b01:   fifo_count <= fifo_count - 3'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // The last word of a command is the one left when the beat countdown reaches zero.
    assign m_valid = (fifo_count != 3'd0);
    assign m_data  = m_valid ? fifo_mem[rd_ptr] : '0;
    assign m_last  = m_valid && (beat_rem == '0);

`ifdef RAM_STREAM_READER_STATS_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stall_q <= 16'h0;
        end else if (accept) begin
            stall_q <= 16'h0;
        end else if (m_valid && !m_ready && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'h1;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0;
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// Scoreboard bench for ram_stream_reader: two instances (read latency 1 and 2) share the
// command and m_ready stimulus; each lane has its own RAM model, expected-beat queue and monitor.
module tb_ram_stream_reader;

    localparam int DW = 8;
    localparam int AW = 10;

    typedef struct {
        logic [DW-1:0] d;
        logic          l;
    } exp_t;

    logic          clk = 1'b0;
    logic          rstn;
    logic          cmd_valid;
    logic [AW-1:0] cmd_addr;
    logic [AW-1:0] cmd_len;
    logic          m_ready;
    int            rdy_mode;
    int            cyc = 0;
    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] mem [1 << AW];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 8'(i);
    end

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = g + 1;

        logic          cmd_ready;
        logic [AW-1:0] ram_addr;
        logic          ram_rd_en;
        logic [DW-1:0] ram_rdata;
        logic          m_valid;
        logic [DW-1:0] m_data;
        logic          m_last;
        logic          busy;
        logic          done;
        logic [15:0]   stall_cnt;
        logic [DW-1:0] p0;
        logic [DW-1:0] p1;

        ram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(LAT)) dut (
            .clk       (clk),
            .rstn      (rstn),
            .cmd_valid (cmd_valid),
            .cmd_ready (cmd_ready),
            .cmd_addr  (cmd_addr),
            .cmd_len   (cmd_len),
            .ram_addr  (ram_addr),
            .ram_rd_en (ram_rd_en),
            .ram_rdata (ram_rdata),
            .m_valid   (m_valid),
            .m_ready   (m_ready),
            .m_data    (m_data),
            .m_last    (m_last),
            .busy      (busy),
            .done      (done),
            .stall_cnt (stall_cnt)
        );

        // RAM answers every cycle from whatever address it samples.
        always @(posedge clk) begin
            p0 <= mem[ram_addr];
            p1 <= p0;
        end
        assign ram_rdata = (LAT == 1) ? p0 : p1;

        wire quiet = !(cmd_ready | m_valid | m_last | ram_rd_en | busy | done) &&
                     m_data == '0 && ram_addr == '0 && stall_cnt == 16'h0;

        exp_t          q[$];
        exp_t          e;
        int            acc_cyc;
        int            first_cyc;
        int            outstanding;
        int            stalls;
        int            cur_len;
        bit            first_seen = 1'b1;
        bit            pend_done;
        bit            exp_done;
        bit            rdy_all;
        bit            prev_stall;
        logic [DW-1:0] prev_data;
        logic          prev_last;

        always @(negedge clk) begin
            if (rstn !== 1'b1) begin
                q.delete();
                pend_done   = 1'b0;
                outstanding = 0;
                first_seen  = 1'b1;
                prev_stall  = 1'b0;
            end else begin
                exp_done  = pend_done;
                pend_done = 1'b0;
                total++;
                if (done !== exp_done) begin
                    bad++;
                    $display("FAIL lane%0d done: got %b want %b at cycle %0d", g, done, exp_done, cyc);
                end
                if (exp_done) begin
                    total++;
                    if (cmd_ready !== 1'b1) begin
                        bad++;
                        $display("FAIL lane%0d ready_in_done: got %b want 1", g, cmd_ready);
                    end
                    total++;
`ifdef RAM_STREAM_READER_STATS_EN
                    if (stall_cnt !== 16'(stalls)) begin
                        bad++;
                        $display("FAIL lane%0d stall_cnt: got %0d want %0d", g, stall_cnt, stalls);
                    end
`else
                    if (stall_cnt !== 16'h0) begin
                        bad++;
                        $display("FAIL lane%0d stall_cnt: got %0d want 0", g, stall_cnt);
                    end
`endif
                end
                if (ram_rd_en === 1'b1) begin
                    total++;
                    if (outstanding >= 4) begin
                        bad++;
                        $display("FAIL lane%0d credit: issued with %0d outstanding, limit 3", g, outstanding);
                    end
                end
                if (prev_stall) begin
                    total++;
                    if (m_valid !== 1'b1 || m_data !== prev_data || m_last !== prev_last) begin
                        bad++;
                        $display("FAIL lane%0d stable: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                                 g, m_valid, m_data, m_last, prev_data, prev_last);
                    end
                end
                if (m_valid === 1'b1 && !first_seen) begin
                    first_seen = 1'b1;
                    first_cyc  = cyc;
                    total++;
                    if (cyc != acc_cyc + LAT + 1) begin
                        bad++;
                        $display("FAIL lane%0d first_valid: got edge %0d want edge %0d", g, cyc, acc_cyc + LAT + 1);
                    end
                end
                if (first_seen && m_ready !== 1'b1) rdy_all = 1'b0;
                if (m_valid === 1'b1 && m_ready !== 1'b1) stalls++;
                if (m_valid === 1'b1 && m_ready === 1'b1) begin
                    total++;
                    if (q.size() == 0) begin
                        bad++;
                        $display("FAIL lane%0d extra_beat: got d=%h want no beat", g, m_data);
                    end else begin
                        e = q.pop_front();
                        if (m_data !== e.d || m_last !== e.l) begin
                            bad++;
                            $display("FAIL lane%0d beat: got d=%h l=%b want d=%h l=%b", g, m_data, m_last, e.d, e.l);
                        end
                        if (e.l) begin
                            pend_done = 1'b1;
                            if (rdy_all) begin
                                total++;
                                if (cyc - first_cyc != cur_len) begin
                                    bad++;
                                    $display("FAIL lane%0d bubbles: got span %0d want %0d", g, cyc - first_cyc, cur_len);
                                end
                            end
                        end
                    end
                end
                prev_stall  = (m_valid === 1'b1) && (m_ready !== 1'b1);
                prev_data   = m_data;
                prev_last   = m_last;
                outstanding = outstanding + int'(ram_rd_en === 1'b1) - int'(m_valid === 1'b1 && m_ready === 1'b1);
                if (cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
                    for (int i = 0; i <= int'(cmd_len); i++) begin
                        q.push_back('{d: 8'((int'(cmd_addr) + i) % (1 << AW)), l: (i == int'(cmd_len))});
                    end
                    acc_cyc    = cyc + 1;
                    first_seen = 1'b0;
                    stalls     = 0;
                    rdy_all    = 1'b1;
                    cur_len    = int'(cmd_len);
                end
            end
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       m_ready = ~m_ready;
                2:       m_ready = 1'($urandom_range(0, 1));
                default: m_ready = 1'b1;
            endcase
        end
    end

    task automatic chk(input string name, input logic act, input logic want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, want);
        end
    endtask

    task automatic run_cmd(input logic [AW-1:0] a, input logic [AW-1:0] l);
        int n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!(lane[0].cmd_ready && lane[1].cmd_ready) && n < 4000);
        if (n >= 4000) begin
            total++;
            bad++;
            $display("FAIL cmd_ready_timeout: got not ready after %0d cycles want ready", n);
        end
        cmd_addr  = a;
        cmd_len   = l;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (n < 5000 && !(lane[0].q.size() == 0 && lane[1].q.size() == 0 &&
                             lane[0].cmd_ready && lane[1].cmd_ready &&
                             !lane[0].pend_done && !lane[1].pend_done)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d/%0d beats pending want 0", lane[0].q.size(), lane[1].q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rstn      = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;
        rdy_mode  = 0;
        repeat (3) @(negedge clk);
        chk("reset_quiet_l1", lane[0].quiet, 1'b1);
        chk("reset_quiet_l2", lane[1].quiet, 1'b1);
        rstn = 1'b1;
        #1;
        chk("ready_before_edge", lane[0].cmd_ready | lane[1].cmd_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("ready_after_edge", lane[0].cmd_ready & lane[1].cmd_ready, 1'b1);

        run_cmd(10'h010, 10'd3);
        drain();
        run_cmd(10'h3FE, 10'd3);
        drain();
        run_cmd(10'h055, 10'd0);
        drain();

        rdy_mode = 1;
        run_cmd(10'h020, 10'd15);
        drain();
        rdy_mode = 0;

        run_cmd(10'h200, 10'd31);
        repeat (8) @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        chk("midrun_quiet_l1", lane[0].quiet, 1'b1);
        chk("midrun_quiet_l2", lane[1].quiet, 1'b1);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("midrun_ready_before_edge", lane[0].cmd_ready | lane[1].cmd_ready, 1'b0);
        @(posedge clk);
        #1;
        chk("midrun_ready_after_edge", lane[0].cmd_ready & lane[1].cmd_ready, 1'b1);
        repeat (6) @(negedge clk);
        run_cmd(10'h0A0, 10'd5);
        drain();

        run_cmd(10'h000, 10'd1);
        run_cmd(10'h100, 10'd1);
        drain();

        run_cmd(10'h123, 10'd1023);
        drain();

        rdy_mode = 2;
        for (int k = 0; k < 12; k++) begin
            run_cmd(10'($urandom), 10'($urandom_range(0, 40)));
        end
        drain();
        rdy_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
